// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format codes, the base
// opcodes that select them, and the datapath-width legality check.
package imm_pkg;

  // Resolved immediate format codes (codes 3'b110 and 3'b111 are illegal)
  localparam logic [2:0] FMT_I     = 3'b000;
  localparam logic [2:0] FMT_S     = 3'b001;
  localparam logic [2:0] FMT_B     = 3'b010;
  localparam logic [2:0] FMT_J     = 3'b011;
  localparam logic [2:0] FMT_U     = 3'b100;
  localparam logic [2:0] FMT_SHAMT = 3'b101;
  localparam logic [2:0] FMT_ILL   = 3'b111;

  // Base opcodes recognised by the automatic decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct3 values of OP_IMM that carry a shift amount instead of an immediate
  localparam logic [2:0] F3_SLLI   = 3'b001;
  localparam logic [2:0] F3_SRXI   = 3'b101;

  // Only RV32 and RV64 datapaths are supported
  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_fmt_ext.sv
// Combinational immediate extractor: given an instruction word and a
// resolved format code, assembles the sign/zero-extended XLEN immediate.
module imm_fmt_ext
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] sh_imm;

  // U immediate is sign-extended above bit 31 only on a 64-bit datapath;
  // shift amounts are 5 bits on RV32 and 6 bits on RV64.
  if (XLEN > 32) begin : g_wide
    assign u_imm  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign sh_imm = {{(XLEN-6){1'b0}}, inst[25:20]};
  end else begin : g_narrow
    assign u_imm  = {inst[31:12], 12'b0};
    assign sh_imm = {{(XLEN-5){1'b0}}, inst[24:20]};
  end

  // Select and assemble the immediate for the resolved format
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:     imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FMT_S:     imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:     imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_J:     imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_U:     imm = u_imm;
      FMT_SHAMT: imm = sh_imm;
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator. Resolves the immediate format (from the
// opcode or an external select), extends the immediate, and buffers results
// in an output register plus one skid register so in_ready is a pure flop.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b1,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Occupancy states: nothing held, OUT held, OUT and SKID held
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic [2:0]       dec_fmt;
  logic [2:0]       fmt_sel;
  logic [XLEN-1:0]  ext_imm;
  logic             ext_ill;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic             ready_q;
  logic             valid_q;
  logic             accept;
  logic             consume;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;

  // Opcode/funct3 to format map used when AUTO_DECODE is set
  always_comb begin
    dec_fmt = FMT_ILL;
    case (in_inst[6:0])
      OP_LOAD, OP_JALR: dec_fmt = FMT_I;
      OP_IMM: begin
        if ((in_inst[14:12] == F3_SLLI) || (in_inst[14:12] == F3_SRXI)) begin
          dec_fmt = FMT_SHAMT;
        end else begin
          dec_fmt = FMT_I;
        end
      end
      OP_STORE:         dec_fmt = FMT_S;
      OP_BRANCH:        dec_fmt = FMT_B;
      OP_JAL:           dec_fmt = FMT_J;
      OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
      default:          dec_fmt = FMT_ILL;
    endcase
  end

  // Choose the decoded format or the externally supplied one
  always_comb begin
    fmt_sel = in_imm_src;
    if (AUTO_DECODE) begin
      fmt_sel = dec_fmt;
    end
  end

  imm_fmt_ext #(
    .XLEN (XLEN)
  ) u_ext (
    .inst    (in_inst),
    .fmt     (fmt_sel),
    .imm     (ext_imm),
    .illegal (ext_ill)
  );

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign accept    = in_valid && ready_q;
  assign consume   = valid_q && out_ready;

  // Next-state and register-load decisions for the OUT/SKID pair
  always_comb begin
    state_n       = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_n      = ST_ONE;
          load_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_n   = ST_FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // accept cannot happen here: ready_q is low while FULL
        if (consume) begin
          state_n       = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // Control flops; ready/valid are registered copies of the next state so
  // neither port has a combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != ST_FULL);
      valid_q <= (state_n != ST_EMPTY);
    end
  end

  // Output register: loads a fresh result or the parked skid entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_imm     <= '0;
      out_fmt     <= '0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (load_out_new) begin
      out_imm     <= ext_imm;
      out_fmt     <= fmt_sel;
      out_illegal <= ext_ill;
      out_tag     <= in_tag;
    end else if (load_out_skid) begin
      out_imm     <= skid_imm;
      out_fmt     <= skid_fmt;
      out_illegal <= skid_ill;
      out_tag     <= skid_tag;
    end
  end

  // Skid register: parks a result accepted while OUT is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_imm <= '0;
      skid_fmt <= '0;
      skid_ill <= 1'b0;
      skid_tag <= '0;
    end else if (load_skid) begin
      skid_imm <= ext_imm;
      skid_fmt <= fmt_sel;
      skid_ill <= ext_ill;
      skid_tag <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (RV32 auto-decode, RV64
// auto-decode, RV32 external select) share one input stream; a queue of
// accepted words is checked against a reference model as entries drain.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_src;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        rdy_a32, val_a32, ill_a32;
  logic [31:0] imm_a32;
  logic [2:0]  fmt_a32;
  logic [4:0]  tag_a32;
  logic        rdy_a64, val_a64, ill_a64;
  logic [63:0] imm_a64;
  logic [2:0]  fmt_a64;
  logic [4:0]  tag_a64;
  logic        rdy_m32, val_m32, ill_m32;
  logic [31:0] imm_m32;
  logic [2:0]  fmt_m32;
  logic [4:0]  tag_m32;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(5)) u_a32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a32),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(val_a32), .out_ready(out_ready), .out_imm(imm_a32),
    .out_fmt(fmt_a32), .out_illegal(ill_a32), .out_tag(tag_a32));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(5)) u_a64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a64),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(val_a64), .out_ready(out_ready), .out_imm(imm_a64),
    .out_fmt(fmt_a64), .out_illegal(ill_a64), .out_tag(tag_a64));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(5)) u_m32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m32),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(val_m32), .out_ready(out_ready), .out_imm(imm_m32),
    .out_fmt(fmt_m32), .out_illegal(ill_m32), .out_tag(tag_m32));

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [4:0]  tag;
  } txn_t;

  txn_t        sb[$];
  int          occ;
  bit          armed;
  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned rmode;   // 0: out_ready high, 1: random, 2: out_ready low

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h67: return 3'd0;
      7'h13:        return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd5 : 3'd0;
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h6F:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      default:      return 3'd7;
    endcase
  endfunction

  // Reference immediates built by left-justifying the field and shifting
  // arithmetically back down.
  function automatic logic [63:0] m_imm(input logic [31:0] i, input logic [2:0] f, input bit x64);
    logic signed [63:0] v;
    case (f)
      3'd0: v = $signed({i[31:20], 52'd0}) >>> 52;
      3'd1: v = $signed({i[31:25], i[11:7], 52'd0}) >>> 52;
      3'd2: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 51'd0}) >>> 51;
      3'd3: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 43'd0}) >>> 43;
      3'd4: v = $signed({i[31:12], 12'd0, 32'd0}) >>> 32;
      3'd5: v = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
      default: v = '0;
    endcase
    if (!x64) v[63:32] = '0;
    return v;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 10))
      0:  w[6:0] = 7'h03;
      1:  w[6:0] = 7'h13;
      2:  w[6:0] = 7'h23;
      3:  w[6:0] = 7'h63;
      4:  w[6:0] = 7'h6F;
      5:  w[6:0] = 7'h67;
      6:  w[6:0] = 7'h37;
      7:  w[6:0] = 7'h17;
      8:  begin w[6:0] = 7'h13; w[14:12] = w[13] ? 3'd5 : 3'd1; end
      9:  w = w;
      default: w = '0;
    endcase
    return w;
  endfunction

  // out_ready driver, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Occupancy model and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    bit   exp_rdy, exp_val;
    txn_t e;
    logic [2:0] fa;
    if (!rst_n) begin
      occ = 0;
      sb.delete();
      armed = 1'b1;
    end else if (armed) begin
      exp_rdy = (occ != 2);
      exp_val = (occ != 0);
      check_eq("a32_in_ready",  rdy_a32, exp_rdy);
      check_eq("a64_in_ready",  rdy_a64, exp_rdy);
      check_eq("m32_in_ready",  rdy_m32, exp_rdy);
      check_eq("a32_out_valid", val_a32, exp_val);
      check_eq("a64_out_valid", val_a64, exp_val);
      check_eq("m32_out_valid", val_m32, exp_val);
      if (exp_val && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
          e  = sb.pop_front();
          fa = m_fmt(e.inst);
          check_eq("a32_imm", {32'd0, imm_a32}, m_imm(e.inst, fa, 1'b0));
          check_eq("a32_fmt", fmt_a32, fa);
          check_eq("a32_ill", ill_a32, fa[2:1] == 2'b11);
          check_eq("a32_tag", tag_a32, e.tag);
          check_eq("a64_imm", imm_a64, m_imm(e.inst, fa, 1'b1));
          check_eq("a64_fmt", fmt_a64, fa);
          check_eq("a64_ill", ill_a64, fa[2:1] == 2'b11);
          check_eq("a64_tag", tag_a64, e.tag);
          check_eq("m32_imm", {32'd0, imm_m32}, m_imm(e.inst, e.src, 1'b0));
          check_eq("m32_fmt", fmt_m32, e.src);
          check_eq("m32_ill", ill_m32, e.src[2:1] == 2'b11);
          check_eq("m32_tag", tag_m32, e.tag);
        end
      end
      occ = occ + ((in_valid && exp_rdy) ? 1 : 0) - ((exp_val && out_ready) ? 1 : 0);
    end
  end

  // Offer one word (entered just after a rising edge) until accepted
  task automatic send(input logic [31:0] inst, input logic [2:0] src, input logic [4:0] tag);
    int unsigned n;
    n = 0;
    in_valid   = 1'b1;
    in_inst    = inst;
    in_imm_src = src;
    in_tag     = tag;
    while (!rdy_a32 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy_a32) begin
      check_eq("send_timeout", rdy_a32, 1'b1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{inst: inst, src: src, tag: tag});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state();
    check_eq("rst_a32_val", val_a32, 1'b0);
    check_eq("rst_a32_rdy", rdy_a32, 1'b1);
    check_eq("rst_a32_imm", imm_a32, 32'd0);
    check_eq("rst_a32_fmt", fmt_a32, 3'd0);
    check_eq("rst_a32_ill", ill_a32, 1'b0);
    check_eq("rst_a32_tag", tag_a32, 5'd0);
    check_eq("rst_a64_imm", imm_a64, 64'd0);
    check_eq("rst_a64_tag", tag_a64, 5'd0);
    check_eq("rst_m32_imm", imm_m32, 32'd0);
    check_eq("rst_m32_fmt", fmt_m32, 3'd0);
    check_eq("rst_m32_ill", ill_m32, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; occ = 0; armed = 1'b0;
    rmode = 0; out_ready = 1'b1;
    rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h00A00293; in_imm_src = 3'd0; in_tag = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;

    // Directed vectors; each result is visible right after its accept edge
    send(32'h00A00293, 3'd0, 5'd1);
    check_eq("addi_lat", val_a32, 1'b1);
    check_eq("addi_imm32", imm_a32, 32'h0000000A);
    check_eq("addi_fmt", fmt_a32, 3'd0);
    check_eq("addi_imm64", imm_a64, 64'h000000000000000A);
    send(32'h0062A423, 3'd0, 5'd2);
    check_eq("sw_imm32", imm_a32, 32'h00000008);
    check_eq("sw_fmt", fmt_a32, 3'd1);
    send(32'hFE521AE3, 3'd0, 5'd3);
    check_eq("br_imm32", imm_a32, 32'hFFFFFFF4);
    check_eq("br_fmt", fmt_a32, 3'd2);
    check_eq("br_imm64", imm_a64, 64'hFFFFFFFFFFFFFFF4);
    send(32'h00309093, 3'd0, 5'd4);
    check_eq("slli_imm32", imm_a32, 32'h00000003);
    check_eq("slli_fmt", fmt_a32, 3'd5);
    send(32'h02309093, 3'd0, 5'd5);
    check_eq("slli6_imm32", imm_a32, 32'h00000003);
    check_eq("slli6_imm64", imm_a64, 64'h0000000000000023);
    send(32'h123450B7, 3'd0, 5'd6);
    check_eq("lui_imm64", imm_a64, 64'h0000000012345000);
    check_eq("lui_fmt", fmt_a64, 3'd4);
    send(32'h800000B7, 3'd0, 5'd7);
    check_eq("luineg_imm64", imm_a64, 64'hFFFFFFFF80000000);
    check_eq("luineg_imm32", imm_a32, 32'h80000000);
    send(32'h00000000, 3'd0, 5'd8);
    check_eq("zero_ill64", ill_a64, 1'b1);
    check_eq("zero_imm64", imm_a64, 64'd0);
    check_eq("zero_fmt64", fmt_a64, 3'd7);
    send(32'h0042A063, 3'd3, 5'd9);
    check_eq("man_j_imm", imm_m32, 32'h0002A004);
    check_eq("man_j_fmt", fmt_m32, 3'd3);
    check_eq("man_j_ill", ill_m32, 1'b0);
    send(32'h0042A063, 3'd6, 5'd10);
    check_eq("man_ill", ill_m32, 1'b1);
    check_eq("man_ill_imm", imm_m32, 32'd0);
    idle(3);

    // Backpressure: two accepted, third blocked until the consumer returns
    rmode = 2;
    idle(2);
    send(rand_inst(), 3'd0, 5'd1);
    send(rand_inst(), 3'd1, 5'd2);
    check_eq("bp_full_rdy", rdy_a32, 1'b0);
    fork
      send(rand_inst(), 3'd2, 5'd3);
      begin idle(3); rmode = 0; end
    join
    for (int i = 0; i < 20; i++) send(rand_inst(), 3'($urandom_range(0, 7)), 5'(i));
    idle(3);

    // Reset while FULL
    rmode = 2;
    idle(2);
    send(rand_inst(), 3'd0, 5'd11);
    send(rand_inst(), 3'd0, 5'd12);
    in_valid = 1'b1; in_inst = 32'h00309093; in_tag = 5'd13;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rmode = 0;
    send(32'h00A00293, 3'd0, 5'd14);
    check_eq("postrst_lat", val_a32, 1'b1);
    check_eq("postrst_imm", imm_a32, 32'h0000000A);
    check_eq("postrst_tag", tag_a32, 5'd14);

    // Random traffic under random backpressure
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rand_inst(), 3'($urandom_range(0, 7)), 5'(i));
    end
    rmode = 0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
    idle(2);
    check_eq("drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
